// File: rtl/hyp_dispatcher.sv
// Operand FIFO and start/busy sequencer in front of the hypotenuse block.
// Results land in a single-entry valid/ready output register.
module hyp_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        hyp_start,
  output logic [7:0]  hyp_a,
  output logic [7:0]  hyp_b,
  input  logic        hyp_busy,
  input  logic [11:0] hyp_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_y,
  output logic        err,
  output logic [7:0]  done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C    = (AW+1)'(DEPTH);
  localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_a_q [DEPTH];
  logic [7:0]  mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [1:0]  wb_cnt_q, wb_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        hyp_start_q, hyp_start_d;
  logic [7:0]  hyp_a_q, hyp_a_d, hyp_b_q, hyp_b_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_y_q, out_y_d;
  logic        err_q, err_d;
  logic [7:0]  done_cnt_q, done_cnt_d;
  logic        push_s, pop_s, load_s;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign in_ready = (count_q < FULL_C);
  assign push_s   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    wb_cnt_d    = wb_cnt_q;
    to_cnt_d    = to_cnt_q;
    hyp_start_d = 1'b0;
    hyp_a_d     = hyp_a_q;
    hyp_b_d     = hyp_b_q;
    err_d       = err_q;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && (!out_valid_q || out_ready) && !hyp_busy) begin
          pop_s       = 1'b1;
          hyp_a_d     = mem_a_q[rd_ptr_q];
          hyp_b_d     = mem_b_q[rd_ptr_q];
          hyp_start_d = 1'b1;
          wb_cnt_d    = 2'd0;
          state_d     = WAIT_BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (hyp_busy) begin
          to_cnt_d = 16'd0;
          state_d  = WAIT_DONE;
        end else if (wb_cnt_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wb_cnt_d = wb_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!hyp_busy) begin
          load_s  = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q == TO_LAST_C) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A freshly loaded result wins over a same-cycle drain of the old one.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    done_cnt_d  = done_cnt_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_y_d     = hyp_y;
      done_cnt_d  = done_cnt_q + 8'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wb_cnt_q    <= 2'd0;
      to_cnt_q    <= 16'd0;
      hyp_start_q <= 1'b0;
      hyp_a_q     <= 8'd0;
      hyp_b_q     <= 8'd0;
      out_valid_q <= 1'b0;
      out_y_q     <= 12'd0;
      err_q       <= 1'b0;
      done_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      wb_cnt_q    <= wb_cnt_d;
      to_cnt_q    <= to_cnt_d;
      hyp_start_q <= hyp_start_d;
      hyp_a_q     <= hyp_a_d;
      hyp_b_q     <= hyp_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      err_q       <= err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign hyp_start = hyp_start_q;
  assign hyp_a     = hyp_a_q;
  assign hyp_b     = hyp_b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign err       = err_q;
  assign done_cnt  = done_cnt_q;

endmodule
